// File: rtl/mm_seq_pkg.sv
// mm_seq_pkg
// Shared types and default constants for the matrix-multiply tile sequencer.
//   mm_seq_state_t : sequencer FSM state encoding (IDLE, STREAM, DRAIN, DONE)
//   MM_LANES       : multiplier lanes per tile edge (informational only)
//   MM_DIM_W       : default width of each minus-one encoded dimension field
//   MM_ADDR_W      : default operand/result line address width
//   MM_MUL_LAT     : default multiplier latency from last fed beat to result
//   mm_cmd_t       : packed command as presented by the command decoder,
//                    sized with the default widths
package mm_seq_pkg;

  localparam int MM_LANES   = 8;
  localparam int MM_DIM_W   = 6;
  localparam int MM_ADDR_W  = 10;
  localparam int MM_MUL_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } mm_seq_state_t;

  typedef struct packed {
    logic [MM_DIM_W-1:0]  m;
    logic [MM_DIM_W-1:0]  k;
    logic [MM_DIM_W-1:0]  n;
    logic [MM_ADDR_W-1:0] a_base;
    logic [MM_ADDR_W-1:0] b_base;
    logic [MM_ADDR_W-1:0] y_base;
    logic                 accum;
  } mm_cmd_t;

endpackage

// File: rtl/mm_seq_delay.sv
// mm_seq_delay
// Valid + flag + payload shift register used to line up the multiplier feed
// strobes and the delayed tile write-back with the read beats.
//   clk        : clock, rising edge
//   reset      : synchronous clear of every stage, active high
//   enable     : low holds every stage
//   in_valid   : beat present this cycle
//   in_flag    : last-beat-of-tile marker for this beat
//   in_data    : payload carried alongside the beat
//   head_valid : stage 0 valid (input delayed by one cycle)
//   head_flag  : stage 0 flag
//   tail_valid : final stage valid (input delayed by DEPTH cycles)
//   tail_flag  : final stage flag
//   tail_data  : final stage payload
//   pending    : some beat still sits in a stage other than the final one
module mm_seq_delay #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         in_valid,
  input  logic         in_flag,
  input  logic [W-1:0] in_data,
  output logic         head_valid,
  output logic         head_flag,
  output logic         tail_valid,
  output logic         tail_flag,
  output logic [W-1:0] tail_data,
  output logic         pending
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] flag_q;
  logic [W-1:0]     data_q [DEPTH];

  // Every stage advances by one position per enabled cycle; a disabled
  // cycle freezes the whole line so downstream timing stays aligned with
  // the stalled upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      flag_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (enable) begin
      valid_q   <= {valid_q[DEPTH-2:0], in_valid};
      flag_q    <= {flag_q[DEPTH-2:0], in_flag};
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign head_valid = valid_q[0];
  assign head_flag  = flag_q[0];
  assign tail_valid = valid_q[DEPTH-1];
  assign tail_flag  = flag_q[DEPTH-1];
  assign tail_data  = data_q[DEPTH-1];

  // The last stage is excluded: once only that stage is occupied, the line
  // is empty after the current cycle.
  assign pending = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer
// Accepts one matrix-multiply command at a time and sequences the operand
// reads, multiplier feed/clear strobes and delayed result tile writes.
// Loop order is k fastest, then B tile (nt), then A row-block (mt).
// Optional feature macro: MM_SEQ_ACCUM_WRITE_EN (latch cmd_accum and drive
// it on wr_accum with every write; otherwise wr_accum is constant 0).
//   clk, reset          : clock and synchronous active-high reset
//   enable              : global enable, low freezes all state
//   cmd_valid/cmd_ready : command handshake, ready only in IDLE
//   cmd_m/cmd_k/cmd_n   : row-tiles / reduction beats / B tiles, minus one
//   cmd_a/b/y_base      : base line addresses
//   cmd_accum           : add-to-memory write request
//   rd_en, rd_addr_a/b  : operand memory read strobe and addresses
//   mul_en, mul_last    : multiplier feed strobe and final-beat clear
//   wr_en, wr_addr      : result tile write strobe and address
//   wr_accum            : write mode, 1 = add to existing contents
//   busy, done          : not idle / one-cycle completion pulse
module mm_tile_sequencer import mm_seq_pkg::*; #(
  parameter int DIM_W   = MM_DIM_W,
  parameter int ADDR_W  = MM_ADDR_W,
  parameter int MUL_LAT = MM_MUL_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DIM_W-1:0]  cmd_m,
  input  logic [DIM_W-1:0]  cmd_k,
  input  logic [DIM_W-1:0]  cmd_n,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  input  logic [ADDR_W-1:0] cmd_y_base,
  input  logic              cmd_accum,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mul_en,
  output logic              mul_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_accum,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = MUL_LAT + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);

  mm_seq_state_t state_q, state_d;

  logic [DIM_W-1:0]  m_q, k_q, n_q;
  logic [DIM_W-1:0]  k_cnt, nt_cnt, mt_cnt;
  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W-1:0] a_row_q;
  logic [ADDR_W-1:0] a_ptr, b_ptr, y_ptr;
  logic              accum_bit;

  logic              last_k, last_n, last_m, final_beat;
  logic              beat_valid;
  logic [ADDR_W:0]   beat_data;
  logic              tail_valid, tail_flag, head_valid, head_flag;
  logic [ADDR_W:0]   tail_data;
  logic              pending;

  assign last_k     = (k_cnt == k_q);
  assign last_n     = (nt_cnt == n_q);
  assign last_m     = (mt_cnt == m_q);
  assign final_beat = last_k & last_n & last_m;
  assign beat_valid = (state_q == ST_STREAM);

  // State register; a disabled cycle holds the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic. STREAM leaves after the final beat; DRAIN waits until
  // only the final delay stage is occupied, so DONE lands exactly one cycle
  // after the last write strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = ST_STREAM;
      ST_STREAM: if (final_beat) state_d = ST_DRAIN;
      ST_DRAIN:  if (!pending) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Command latch and address walkers. Addresses are built incrementally:
  // within a tile both pointers step by one; moving to the next B tile
  // rewinds A to the start of its row-block while B simply continues, and
  // moving to the next A row-block restarts B from its base while A
  // continues. Result tiles are contiguous in mt*N+nt order, so the result
  // pointer just steps once per finished tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      k_cnt    <= '0;
      nt_cnt   <= '0;
      mt_cnt   <= '0;
      b_base_q <= '0;
      a_row_q  <= '0;
      a_ptr    <= '0;
      b_ptr    <= '0;
      y_ptr    <= '0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            m_q      <= cmd_m;
            k_q      <= cmd_k;
            n_q      <= cmd_n;
            k_cnt    <= '0;
            nt_cnt   <= '0;
            mt_cnt   <= '0;
            b_base_q <= cmd_b_base;
            a_row_q  <= cmd_a_base;
            a_ptr    <= cmd_a_base;
            b_ptr    <= cmd_b_base;
            y_ptr    <= cmd_y_base;
          end
        end
        ST_STREAM: begin
          if (!last_k) begin
            k_cnt <= k_cnt + DIM_ONE;
            a_ptr <= a_ptr + ADDR_ONE;
            b_ptr <= b_ptr + ADDR_ONE;
          end else begin
            k_cnt <= '0;
            y_ptr <= y_ptr + ADDR_ONE;
            if (!last_n) begin
              nt_cnt <= nt_cnt + DIM_ONE;
              a_ptr  <= a_row_q;
              b_ptr  <= b_ptr + ADDR_ONE;
            end else begin
              nt_cnt  <= '0;
              mt_cnt  <= mt_cnt + DIM_ONE;
              b_ptr   <= b_base_q;
              a_row_q <= a_ptr + ADDR_ONE;
              a_ptr   <= a_ptr + ADDR_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MM_SEQ_ACCUM_WRITE_EN
  logic accum_q;

  // Write mode captured with the command and applied to all of its writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      accum_q <= 1'b0;
    end else if (enable && state_q == ST_IDLE && cmd_valid) begin
      accum_q <= cmd_accum;
    end
  end

  assign accum_bit = accum_q;
`else
  logic unused_cmd_accum;
  assign unused_cmd_accum = cmd_accum;
  assign accum_bit        = 1'b0;
`endif

  // Payload is zeroed on idle beats so the write address bus rests at 0.
  assign beat_data = beat_valid ? {y_ptr, accum_bit} : '0;

  mm_seq_delay #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + 1)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (beat_valid),
    .in_flag    (beat_valid & last_k),
    .in_data    (beat_data),
    .head_valid (head_valid),
    .head_flag  (head_flag),
    .tail_valid (tail_valid),
    .tail_flag  (tail_flag),
    .tail_data  (tail_data),
    .pending    (pending)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rd_en     = beat_valid;
  assign rd_addr_a = a_ptr;
  assign rd_addr_b = b_ptr;
  assign mul_en    = head_valid;
  assign mul_last  = head_valid & head_flag;
  assign wr_en     = tail_valid & tail_flag;
  assign wr_addr   = wr_en ? tail_data[ADDR_W:1] : '0;
  assign wr_accum  = wr_en & tail_data[0];

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb_mm_tile_sequencer
// Directed bench for mm_tile_sequencer with MUL_LAT=3. Each scenario task
// issues a command, records the strobes it sees on enabled cycles (cycle
// numbers counted from the handshake) and compares against hand-derived
// expectations.
module tb_mm_tile_sequencer;
  import mm_seq_pkg::*;

  localparam int MUL_LAT = 3;
`ifdef MM_SEQ_ACCUM_WRITE_EN
  localparam logic ACC_EXP = 1'b1;
`else
  localparam logic ACC_EXP = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [MM_DIM_W-1:0]  cmd_m, cmd_k, cmd_n;
  logic [MM_ADDR_W-1:0] cmd_a_base, cmd_b_base, cmd_y_base;
  logic                 cmd_accum;
  logic                 rd_en;
  logic [MM_ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic                 mul_en, mul_last;
  logic                 wr_en;
  logic [MM_ADDR_W-1:0] wr_addr;
  logic                 wr_accum;
  logic                 busy, done;

  mm_tile_sequencer #(
    .DIM_W   (MM_DIM_W),
    .ADDR_W  (MM_ADDR_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_m      (cmd_m),
    .cmd_k      (cmd_k),
    .cmd_n      (cmd_n),
    .cmd_a_base (cmd_a_base),
    .cmd_b_base (cmd_b_base),
    .cmd_y_base (cmd_y_base),
    .cmd_accum  (cmd_accum),
    .rd_en      (rd_en),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .mul_en     (mul_en),
    .mul_last   (mul_last),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_accum   (wr_accum),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  int rd_a_q[$];
  int rd_b_q[$];
  int rd_cyc_q[$];
  int ml_cyc_q[$];
  int wr_addr_q[$];
  int wr_cyc_q[$];
  int wr_acc_q[$];
  int done_cyc;

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Issues one command from IDLE and records events until done or budget.
  // Cycle 1 is the first cycle after the handshake edge. Enable is dropped
  // for stall_len cycles starting at cycle stall_at.
  task automatic run_cmd(input mm_cmd_t c, input int stall_at, input int stall_len);
    rd_a_q.delete();
    rd_b_q.delete();
    rd_cyc_q.delete();
    ml_cyc_q.delete();
    wr_addr_q.delete();
    wr_cyc_q.delete();
    wr_acc_q.delete();
    done_cyc   = -1;
    cmd_m      = c.m;
    cmd_k      = c.k;
    cmd_n      = c.n;
    cmd_a_base = c.a_base;
    cmd_b_base = c.b_base;
    cmd_y_base = c.y_base;
    cmd_accum  = c.accum;
    cmd_valid  = 1'b1;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      enable = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (enable) begin
        if (rd_en) begin
          rd_a_q.push_back(int'(rd_addr_a));
          rd_b_q.push_back(int'(rd_addr_b));
          rd_cyc_q.push_back(cyc);
        end
        if (mul_en && mul_last) ml_cyc_q.push_back(cyc);
        if (wr_en) begin
          wr_addr_q.push_back(int'(wr_addr));
          wr_cyc_q.push_back(cyc);
          wr_acc_q.push_back(int'(wr_accum));
        end
        if (done) begin
          done_cyc = cyc;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset.cmd_ready got %b expected 1", cmd_ready);
    end
    n_vec++;
    if ({busy, done, rd_en, mul_en, mul_last, wr_en, wr_accum} !== 7'b0) begin
      n_err++;
      $display("[TB] FAIL reset.strobes got %b expected 0000000",
               {busy, done, rd_en, mul_en, mul_last, wr_en, wr_accum});
    end
    n_vec++;
    if ({rd_addr_a, rd_addr_b, wr_addr} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset.addrs got a=%0d b=%0d y=%0d expected 0/0/0",
               rd_addr_a, rd_addr_b, wr_addr);
    end
  endtask

  task automatic test_single_tile();
    mm_cmd_t c;
    c = '0;
    c.k = 3; c.a_base = 0; c.b_base = 16; c.y_base = 32;
    run_cmd(c, 1000, 0);
    n_vec++;
    if (rd_cyc_q.size() != 4) begin
      n_err++;
      $display("[TB] FAIL single.rd_count got %0d expected 4", rd_cyc_q.size());
    end
    for (int i = 0; i < rd_cyc_q.size(); i++) begin
      n_vec++;
      if (rd_a_q[i] != i || rd_b_q[i] != 16 + i || rd_cyc_q[i] != i + 1) begin
        n_err++;
        $display("[TB] FAIL single.rd[%0d] got a=%0d b=%0d cyc=%0d expected a=%0d b=%0d cyc=%0d",
                 i, rd_a_q[i], rd_b_q[i], rd_cyc_q[i], i, 16 + i, i + 1);
      end
    end
    n_vec++;
    if (ml_cyc_q.size() != 1 || ml_cyc_q[0] != 5) begin
      n_err++;
      $display("[TB] FAIL single.mul_last got count=%0d first=%0d expected count=1 cyc=5",
               ml_cyc_q.size(), (ml_cyc_q.size() > 0) ? ml_cyc_q[0] : -1);
    end
    n_vec++;
    if (wr_cyc_q.size() != 1 || wr_cyc_q[0] != 8 || wr_addr_q[0] != 32) begin
      n_err++;
      $display("[TB] FAIL single.wr got count=%0d cyc=%0d addr=%0d expected 1/8/32",
               wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1,
               (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1);
    end
    n_vec++;
    if (done_cyc != 9) begin
      n_err++;
      $display("[TB] FAIL single.done_cycle got %0d expected 9", done_cyc);
    end
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL single.after_done got ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  // M=2, N=3, K=2 with optional stall; all cycle expectations past the stall
  // start move by stall_len.
  task automatic check_multi(input string tag, input int stall_at, input int stall_len);
    mm_cmd_t c;
    int      exp_cyc;
    c = '0;
    c.m = 1; c.k = 1; c.n = 2; c.a_base = 100; c.b_base = 200; c.y_base = 300;
    run_cmd(c, stall_at, stall_len);
    n_vec++;
    if (rd_cyc_q.size() != 12) begin
      n_err++;
      $display("[TB] FAIL %s.rd_count got %0d expected 12", tag, rd_cyc_q.size());
    end
    for (int i = 0; i < rd_cyc_q.size(); i++) begin
      exp_cyc = i + 1;
      if (exp_cyc >= stall_at) exp_cyc += stall_len;
      n_vec++;
      if (rd_a_q[i] != 100 + (i / 6) * 2 + (i % 2) || rd_b_q[i] != 200 + (i % 6)
          || rd_cyc_q[i] != exp_cyc) begin
        n_err++;
        $display("[TB] FAIL %s.rd[%0d] got a=%0d b=%0d cyc=%0d expected a=%0d b=%0d cyc=%0d",
                 tag, i, rd_a_q[i], rd_b_q[i], rd_cyc_q[i],
                 100 + (i / 6) * 2 + (i % 2), 200 + (i % 6), exp_cyc);
      end
    end
    n_vec++;
    if (wr_cyc_q.size() != 6) begin
      n_err++;
      $display("[TB] FAIL %s.wr_count got %0d expected 6", tag, wr_cyc_q.size());
    end
    for (int j = 0; j < wr_cyc_q.size(); j++) begin
      exp_cyc = 6 + 2 * j;
      if (exp_cyc >= stall_at) exp_cyc += stall_len;
      n_vec++;
      if (wr_addr_q[j] != 300 + j || wr_cyc_q[j] != exp_cyc) begin
        n_err++;
        $display("[TB] FAIL %s.wr[%0d] got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                 tag, j, wr_addr_q[j], wr_cyc_q[j], 300 + j, exp_cyc);
      end
    end
    n_vec++;
    if (ml_cyc_q.size() != 6) begin
      n_err++;
      $display("[TB] FAIL %s.mul_last_count got %0d expected 6", tag, ml_cyc_q.size());
    end
    exp_cyc = 17;
    if (exp_cyc >= stall_at) exp_cyc += stall_len;
    n_vec++;
    if (done_cyc != exp_cyc) begin
      n_err++;
      $display("[TB] FAIL %s.done_cycle got %0d expected %0d", tag, done_cyc, exp_cyc);
    end
  endtask

  task automatic test_multi_tile();
    check_multi("multi", 1000, 0);
  endtask

  task automatic test_stall();
    check_multi("stall", 4, 5);
  endtask

  task automatic test_back_to_back();
    mm_cmd_t c;
    c = '0;
    c.k = 0; c.n = 3; c.a_base = 10; c.b_base = 20; c.y_base = 50;
    run_cmd(c, 1000, 0);
    n_vec++;
    if (rd_cyc_q.size() != 4 || ml_cyc_q.size() != 4) begin
      n_err++;
      $display("[TB] FAIL k1.counts got rd=%0d mul_last=%0d expected 4/4",
               rd_cyc_q.size(), ml_cyc_q.size());
    end
    for (int i = 0; i < rd_cyc_q.size(); i++) begin
      n_vec++;
      if (rd_a_q[i] != 10 || rd_b_q[i] != 20 + i) begin
        n_err++;
        $display("[TB] FAIL k1.rd[%0d] got a=%0d b=%0d expected a=10 b=%0d",
                 i, rd_a_q[i], rd_b_q[i], 20 + i);
      end
    end
    n_vec++;
    if (wr_cyc_q.size() != 4) begin
      n_err++;
      $display("[TB] FAIL k1.wr_count got %0d expected 4", wr_cyc_q.size());
    end
    for (int j = 0; j < wr_cyc_q.size(); j++) begin
      n_vec++;
      if (wr_addr_q[j] != 50 + j || wr_cyc_q[j] != 5 + j) begin
        n_err++;
        $display("[TB] FAIL k1.wr[%0d] got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                 j, wr_addr_q[j], wr_cyc_q[j], 50 + j, 5 + j);
      end
    end
    n_vec++;
    if (done_cyc != 9) begin
      n_err++;
      $display("[TB] FAIL k1.done_cycle got %0d expected 9", done_cyc);
    end
  endtask

  // M=2, N=2, K=3: first write at cycle 7, reset during cycle 9 drops the
  // second write that would appear at cycle 10.
  task automatic test_reset_mid();
    int first_wr;
    int late_wr;
    int late_done;
    first_wr   = -1;
    cmd_m      = 1;
    cmd_k      = 2;
    cmd_n      = 1;
    cmd_a_base = 0;
    cmd_b_base = 40;
    cmd_y_base = 80;
    cmd_accum  = 1'b0;
    cmd_valid  = 1'b1;
    enable     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL rstmid.busy got ready=%b busy=%b expected 0/1", cmd_ready, busy);
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (wr_en && first_wr < 0) first_wr = cyc;
      if (first_wr >= 0 && cyc == first_wr + 2) begin
        reset = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (first_wr != 7) begin
      n_err++;
      $display("[TB] FAIL rstmid.first_wr got %0d expected 7", first_wr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0
        || mul_en !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rstmid.after_reset got ready=%b busy=%b wr=%b rd=%b mul=%b expected 1/0/0/0/0",
               cmd_ready, busy, wr_en, rd_en, mul_en);
    end
    late_wr   = 0;
    late_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (wr_en) late_wr++;
      if (done) late_done++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (late_wr != 0 || late_done != 0) begin
      n_err++;
      $display("[TB] FAIL rstmid.dropped got wr=%0d done=%0d expected 0/0", late_wr, late_done);
    end
  endtask

  task automatic test_accum();
    mm_cmd_t c;
    c = '0;
    c.k = 1; c.n = 1; c.a_base = 3; c.b_base = 9; c.y_base = 7; c.accum = 1'b1;
    run_cmd(c, 1000, 0);
    n_vec++;
    if (wr_cyc_q.size() != 2) begin
      n_err++;
      $display("[TB] FAIL accum1.wr_count got %0d expected 2", wr_cyc_q.size());
    end
    for (int j = 0; j < wr_cyc_q.size(); j++) begin
      n_vec++;
      if (wr_acc_q[j] != int'(ACC_EXP) || wr_addr_q[j] != 7 + j) begin
        n_err++;
        $display("[TB] FAIL accum1.wr[%0d] got accum=%0d addr=%0d expected accum=%0d addr=%0d",
                 j, wr_acc_q[j], wr_addr_q[j], ACC_EXP, 7 + j);
      end
    end
    c.accum = 1'b0;
    run_cmd(c, 1000, 0);
    n_vec++;
    if (wr_cyc_q.size() != 2) begin
      n_err++;
      $display("[TB] FAIL accum0.wr_count got %0d expected 2", wr_cyc_q.size());
    end
    for (int j = 0; j < wr_cyc_q.size(); j++) begin
      n_vec++;
      if (wr_acc_q[j] != 0) begin
        n_err++;
        $display("[TB] FAIL accum0.wr[%0d] got accum=%0d expected 0", j, wr_acc_q[j]);
      end
    end
  endtask

  // Scenario sequence; every scenario starts and ends with the DUT in IDLE.
  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_m      = '0;
    cmd_k      = '0;
    cmd_n      = '0;
    cmd_a_base = '0;
    cmd_b_base = '0;
    cmd_y_base = '0;
    cmd_accum  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_accum();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
